sdram_loader_arbiter: RTL and testbench

- Shares the single SDRAM controller port between the file loader/eraser write stream and the CPU memory port.
- The loader issues single-cycle, unstallable write strobes during download and erase. This block buffers them in a small FIFO and interleaves them with CPU reads and writes under bounded-latency priority.
- Sits between the loader, the CPU memory interface and the SDRAM controller, all in the system clock domain.

---
 rtl/sdram_loader_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sdram_loader_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_loader_arbiter.sv
// Shares one SDRAM controller port between the loader write FIFO and the CPU.
// Ports: clk/reset, ld_* strobe in, cpu_* req/ack, mem_* req/ack, fifo_level, overflow.
module sdram_loader_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int LD_BURST   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_wr,
  input  logic [24:0]                   ld_addr,
  input  logic [7:0]                    ld_data,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [24:0]                   cpu_addr,
  input  logic [7:0]                    cpu_din,
  output logic [7:0]                    cpu_dout,
  output logic                          cpu_ack,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [24:0]                   mem_addr,
  output logic [7:0]                    mem_din,
  input  logic [7:0]                    mem_dout,
  input  logic                          mem_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(LD_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    LD_ACC,
    CPU_ACC
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [24:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;

  // Entry layout: {addr[24:0], data[7:0]}
  logic [32:0]   fifo_q [FIFO_DEPTH];
  logic [32:0]   head;

  logic fifo_empty;
  logic fifo_full;
  logic ld_win;
  logic cpu_win;
  logic push;
  logic pop;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

  // A pending CPU request only blocks the loader once the burst budget is
  // spent; during the cpu_ack cycle the CPU has already dropped its request.
  assign ld_win  = !fifo_empty &&
                   (!cpu_req || cpu_ack_q ||
                    (burst_q < BW'(LD_BURST)));
  assign cpu_win = cpu_req && !cpu_ack_q;

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_win) begin
          pop        = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = head[32:8];
          mem_din_d  = head[7:0];
          state_d    = LD_ACC;
          if (burst_q != BW'(LD_BURST)) begin
            burst_d = burst_q + BW'(1);
          end
        end else if (cpu_win) begin
          mem_req_d  = 1'b1;
          mem_we_d   = cpu_we;
          mem_addr_d = cpu_addr;
          mem_din_d  = cpu_din;
          state_d    = CPU_ACC;
          burst_d    = '0;
        end else if (fifo_empty) begin
          burst_d = '0;
        end
      end
      LD_ACC: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CPU_ACC: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          cpu_ack_d  = 1'b1;
          cpu_dout_d = mem_dout;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a strobe at full still lands.
  always_comb begin
    push     = ld_wr && (!fifo_full || pop);
    ovf_d    = ovf_q || (ld_wr && fifo_full && !pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {ld_addr, ld_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sdram_loader_arbiter.sv
// Bench for sdram_loader_arbiter: queue-based reference model plus
// directed and randomized traffic from loader, CPU and SDRAM agents.
module tb_sdram_loader_arbiter;

  localparam int DEPTH = 8;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_wr;
  logic [24:0] ld_addr;
  logic [7:0]  ld_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_ack;
  logic [3:0]  fifo_level;
  logic        overflow;

  always #5 clk = ~clk;

  sdram_loader_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .LD_BURST(BURST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld_wr(ld_wr),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_ack(mem_ack),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, owner of the port as 0/1/2.
  logic [32:0] mq[$];
  int          m_owner;
  int          m_burst;
  bit          m_pop;
  bit          m_ackwas;
  bit          m_cur_rd;
  bit          e_req;
  bit          e_we;
  logic [24:0] e_addr;
  logic [7:0]  e_din;
  logic [7:0]  e_dout;
  bit          e_ack;
  bit          e_rd;
  bit          e_ovf;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_owner = 0;
      m_burst = 0;
      e_req = 0;
      e_we = 0;
      e_addr = '0;
      e_din = '0;
      e_dout = '0;
      e_ack = 0;
      e_rd = 0;
      e_ovf = 0;
    end else begin
      m_pop = 0;
      m_ackwas = e_ack;
      e_ack = 0;
      if (m_owner == 0) begin
        if (mq.size() > 0 &&
            (!cpu_req || m_ackwas || m_burst < BURST)) begin
          m_pop = 1;
          e_req = 1;
          e_we = 1;
          {e_addr, e_din} = mq[0];
          m_owner = 1;
          m_burst = (m_burst < BURST) ? m_burst + 1 : BURST;
        end else if (cpu_req && !m_ackwas) begin
          e_req = 1;
          e_we = cpu_we;
          e_addr = cpu_addr;
          e_din = cpu_din;
          m_owner = 2;
          m_burst = 0;
          m_cur_rd = !cpu_we;
        end else if (mq.size() == 0) begin
          m_burst = 0;
        end
      end else if (mem_ack) begin
        e_req = 0;
        if (m_owner == 2) begin
          e_ack = 1;
          e_dout = mem_dout;
          e_rd = m_cur_rd;
        end
        m_owner = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (ld_wr) begin
        if (mq.size() < DEPTH) mq.push_back({ld_addr, ld_data});
        else e_ovf = 1;
      end
    end
  end

  task automatic check_outputs();
    chk("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_din", 32'(mem_din), 32'(e_din));
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    if (e_ack && e_rd) chk("cpu_dout", 32'(cpu_dout), 32'(e_dout));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  // Agent state
  int          lat = 1;
  bit          hold = 0;
  int          acnt = 0;
  bit          rand_dout = 1;
  logic [7:0]  fix_dout = 8'h00;
  bit          cpu_auto = 0;
  bit          cpu_wr_only = 0;
  int          cpu_pct = 0;
  int          cpu_issued = 0;
  int          cpu_acked = 0;
  bit          rec_order = 0;
  bit          prev_req = 0;
  string       order = "";
  logic [24:0] ld_log[$];

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (rec_order && mem_req && !prev_req) begin
      if (mem_we) order = {order, "L"};
      else order = {order, "C"};
    end
    prev_req = mem_req;
    if (cpu_ack) begin
      cpu_acked++;
      cpu_req = 1'b0;
    end else if (cpu_auto && !cpu_req &&
                 $urandom_range(99) < cpu_pct) begin
      cpu_req = 1'b1;
      cpu_we = cpu_wr_only ? 1'b1 : 1'($urandom_range(1));
      cpu_addr = 25'($urandom_range(32'h0FFFFF));
      cpu_din = 8'($urandom);
      cpu_issued++;
    end
    mem_ack = 1'b0;
    if (mem_req && !hold) begin
      acnt++;
      if (acnt >= lat) begin
        mem_ack = 1'b1;
        mem_dout = rand_dout ? 8'($urandom) : fix_dout;
        acnt = 0;
        if (mem_we && mem_addr >= 25'h100000 &&
            mem_addr < 25'h200000) ld_log.push_back(mem_addr);
      end
    end else begin
      acnt = 0;
    end
  endtask

  // which: 0 mem_req high, 1 cpu_ack high, 2 fully drained and idle
  task automatic wait_sig(input string nm, input int which,
                          input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (which == 0) ok = mem_req;
      else if (which == 1) ok = cpu_ack;
      else ok = !mem_req && !cpu_req && !cpu_ack &&
                (fifo_level == 0);
      if (ok) break;
      cycle();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ld_wr = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_din = '0;
    mem_dout = '0;
    mem_ack = 1'b0;
    cycle();
    cycle();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;

    // Single loader byte
    lat = 3;
    ld_wr = 1'b1;
    ld_addr = 25'h200000;
    ld_data = 8'hA5;
    cycle();
    ld_wr = 1'b0;
    chk("t1_level1", 32'(fifo_level), 1);
    chk("t1_noreq", 32'(mem_req), 0);
    cycle();
    chk("t1_req", 32'(mem_req), 1);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", 32'(mem_addr), 32'h200000);
    chk("t1_din", 32'(mem_din), 32'hA5);
    chk("t1_level0", 32'(fifo_level), 0);
    cycle();
    chk("t1_hold", 32'(mem_req), 1);
    wait_sig("t1_drain", 2, 20);

    // CPU read, then a req still high during the ack cycle
    rand_dout = 0;
    fix_dout = 8'h3C;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 25'h170010;
    wait_sig("t2_grant", 0, 10);
    chk("t2_we", 32'(mem_we), 0);
    chk("t2_addr", 32'(mem_addr), 32'h170010);
    wait_sig("t2_ack", 1, 20);
    chk("t2_dout", 32'(cpu_dout), 32'h3C);
    cpu_req = 1'b1;
    cycle();
    cpu_req = 1'b0;
    chk("t2_ack_once", 32'(cpu_ack), 0);
    chk("t2_no_regrant", 32'(mem_req), 0);
    cycle();
    chk("t2_no_regrant2", 32'(mem_req), 0);
    rand_dout = 1;

    // Fairness: loader burst then CPU
    lat = 1;
    hold = 1;
    order = "";
    prev_req = mem_req;
    rec_order = 1;
    for (int i = 0; i < 9; i++) begin
      ld_wr = 1'b1;
      ld_addr = 25'h300000 + 25'(i);
      ld_data = 8'(i);
      cycle();
    end
    ld_wr = 1'b0;
    chk("t3_level8", 32'(fifo_level), 8);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 25'h000123;
    hold = 0;
    wait_sig("t3_cpu_ack", 1, 80);
    ld_wr = 1'b1;
    ld_addr = 25'h300009;
    ld_data = 8'h09;
    cycle();
    ld_wr = 1'b0;
    wait_sig("t3_drain", 2, 80);
    rec_order = 0;
    checks++;
    if (order != "LLLLCLLLLLL") begin
      errors++;
      $display("FAIL t3_order actual=%s required=LLLLCLLLLLL", order);
    end
    chk("t3_ovf", 32'(overflow), 0);

    // Overflow with the port blocked by a stalled CPU access
    do_reset();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 25'h000456;
    cpu_din = 8'h11;
    hold = 1;
    wait_sig("t4_cpu_grant", 0, 10);
    for (int i = 0; i < 9; i++) begin
      ld_wr = 1'b1;
      ld_addr = 25'h400000 + 25'(i);
      ld_data = 8'(8'h40 + i);
      cycle();
    end
    ld_wr = 1'b0;
    chk("t4_full", 32'(fifo_level), 8);
    chk("t4_ovf", 32'(overflow), 1);
    hold = 0;
    wait_sig("t4_ack", 1, 20);
    wait_sig("t4_drain", 2, 80);
    chk("t4_sticky", 32'(overflow), 1);
    do_reset();
    cpu_req = 1'b1;
    hold = 1;
    wait_sig("t4b_grant", 0, 10);
    for (int i = 0; i < 8; i++) begin
      ld_wr = 1'b1;
      ld_addr = 25'h410000 + 25'(i);
      ld_data = 8'(i);
      cycle();
    end
    ld_wr = 1'b0;
    chk("t4b_full", 32'(fifo_level), 8);
    chk("t4b_noovf", 32'(overflow), 0);
    hold = 0;
    wait_sig("t4b_ack", 1, 20);
    ld_wr = 1'b1;
    ld_addr = 25'h4100FF;
    ld_data = 8'hFF;
    cycle();
    ld_wr = 1'b0;
    chk("t4b_pushpop_lvl", 32'(fifo_level), 8);
    chk("t4b_pushpop_ovf", 32'(overflow), 0);
    wait_sig("t4b_drain", 2, 80);
    chk("t4b_ovf_end", 32'(overflow), 0);

    // Reset during a loader access, then a stray ack
    hold = 1;
    ld_wr = 1'b1;
    ld_addr = 25'h500000;
    ld_data = 8'h55;
    cycle();
    ld_wr = 1'b0;
    wait_sig("t5_grant", 0, 10);
    do_reset();
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_level", 32'(fifo_level), 0);
    chk("t5_ovf", 32'(overflow), 0);
    mem_ack = 1'b1;
    mem_dout = 8'h77;
    cycle();
    chk("t5_no_ack", 32'(cpu_ack), 0);
    chk("t5_no_req", 32'(mem_req), 0);
    cycle();
    chk("t5_no_ack2", 32'(cpu_ack), 0);
    chk("t5_level2", 32'(fifo_level), 0);
    hold = 0;

    // Erase stream with interleaved CPU writes at latency 6
    do_reset();
    lat = 6;
    ld_log.delete();
    cpu_issued = 0;
    cpu_acked = 0;
    cpu_auto = 1;
    cpu_wr_only = 1;
    cpu_pct = 10;
    for (int i = 0; i < 64; i++) begin
      ld_wr = 1'b1;
      ld_addr = 25'h100000 + 25'(i);
      ld_data = 8'hFF;
      cycle();
      ld_wr = 1'b0;
      repeat (31) cycle();
    end
    cpu_auto = 0;
    wait_sig("t6_drain", 2, 100);
    chk("t6_count", 32'(ld_log.size()), 64);
    begin
      bit inorder;
      inorder = (ld_log.size() == 64);
      foreach (ld_log[i])
        if (ld_log[i] != 25'h100000 + 25'(i)) inorder = 0;
      chk("t6_inorder", 32'(inorder), 1);
    end
    chk("t6_cpu_acks", 32'(cpu_acked), 32'(cpu_issued));
    chk("t6_ovf", 32'(overflow), 0);

    // Randomized mixed traffic
    do_reset();
    cpu_auto = 1;
    cpu_wr_only = 0;
    cpu_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      ld_wr = ($urandom_range(99) < 35);
      ld_addr = 25'($urandom);
      ld_data = 8'($urandom);
      reset = (i == 1500);
      cycle();
    end
    reset = 1'b0;
    ld_wr = 1'b0;
    cpu_auto = 0;
    wait_sig("t7_drain", 2, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
